// File: rtl/hdsiso_pkg.sv
// Shared types and constants for the SISO latch-chain write driver.
package hdsiso_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PH_B,
        GAP_B,
        PH_A,
        GAP_A
    } hdsiso_state_t;

    localparam int HDSISO_PULSE_DEF = 2;
    localparam int HDSISO_GAP_DEF   = 1;
    localparam int HDSISO_BYTE_W    = 8;

    function automatic int hdsiso_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hdsiso_phase_timer.sv
// Loadable down-counter that times both gate pulses and non-overlap gaps.
// done_o is high while the count is zero; a load of N therefore yields N+1
// cycles before done_o is seen in the loaded phase.
module hdsiso_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/hdsiso_gate_writer.sv
// Write-side driver for the transparent-high latch SISO chain.
// Serializes bytes MSB-first onto sdata and produces two non-overlapping
// gate phases (gate_b for even stages, then gate_a for odd stages).
// Optional feature macro: HDSISO_FLUSH_EN adds a flush input that shifts
// DEPTH zero bits through the chain.
module hdsiso_gate_writer
    import hdsiso_pkg::*;
#(
    parameter int PULSE_CYCLES = HDSISO_PULSE_DEF,
    parameter int GAP_CYCLES   = HDSISO_GAP_DEF,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [HDSISO_BYTE_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     sdata,
    output logic                     gate_a,
    output logic                     gate_b,
    output logic                     busy
`ifdef HDSISO_FLUSH_EN
    ,
    input  logic                     flush
`endif
);

    localparam int CNT_W = $clog2(hdsiso_max(PULSE_CYCLES, GAP_CYCLES) + 1);
`ifdef HDSISO_FLUSH_EN
    // Must hold both the byte index 7 and the flush index DEPTH-1.
    localparam int BIT_W = hdsiso_max(3, $clog2(hdsiso_max(DEPTH, 2)));
`else
    // DEPTH only matters when the flush feature is built in.
    localparam int BIT_W = (DEPTH > 0) ? 3 : 3;
`endif

    hdsiso_state_t            state_q, state_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [HDSISO_BYTE_W-1:0] shift_q, shift_d;
    logic                     sdata_q, sdata_d;
    logic                     gate_a_q, gate_a_d;
    logic                     gate_b_q, gate_b_d;
    logic                     busy_q, busy_d;
    logic                     in_ready_q, in_ready_d;

    logic                     tmr_load;
    logic [CNT_W-1:0]         tmr_val;
    logic                     tmr_done;
    logic                     start_flush;
    logic                     accept;

`ifdef HDSISO_FLUSH_EN
    assign start_flush = flush & in_ready_q;
`else
    assign start_flush = 1'b0;
`endif
    assign accept = in_valid & in_ready_q;

    hdsiso_phase_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_i     (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .done_o    (tmr_done)
    );

    // Next-state, datapath and output decode; outputs are taken from the
    // next state so that every pin leaves a flop.
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        sdata_d  = sdata_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE: begin
                sdata_d = 1'b0;
                if (start_flush) begin
                    shift_d = '0;
                    bit_d   = BIT_W'(DEPTH - 1);
                    state_d = SETUP;
                end else if (accept) begin
                    shift_d = in_data;
                    bit_d   = BIT_W'(HDSISO_BYTE_W - 1);
                    sdata_d = in_data[HDSISO_BYTE_W-1];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d  = PH_B;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(PULSE_CYCLES - 1);
            end
            PH_B: begin
                if (tmr_done) begin
                    state_d  = GAP_B;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(GAP_CYCLES - 1);
                end
            end
            GAP_B: begin
                if (tmr_done) begin
                    state_d  = PH_A;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(PULSE_CYCLES - 1);
                end
            end
            PH_A: begin
                if (tmr_done) begin
                    state_d  = GAP_A;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(GAP_CYCLES - 1);
                end
            end
            GAP_A: begin
                if (tmr_done) begin
                    if (bit_q == '0) begin
                        state_d = IDLE;
                        sdata_d = 1'b0;
                    end else begin
                        bit_d   = bit_q - 1'b1;
                        shift_d = shift_q << 1;
                        sdata_d = shift_q[HDSISO_BYTE_W-2];
                        state_d = SETUP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        gate_a_d   = (state_d == PH_A);
        gate_b_d   = (state_d == PH_B);
    end

    // State and output registers; reset forces both gates low at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            shift_q    <= '0;
            sdata_q    <= 1'b0;
            gate_a_q   <= 1'b0;
            gate_b_q   <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            sdata_q    <= sdata_d;
            gate_a_q   <= gate_a_d;
            gate_b_q   <= gate_b_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign sdata    = sdata_q;
    assign gate_a   = gate_a_q;
    assign gate_b   = gate_b_q;
    assign busy     = busy_q;

endmodule

// File: doc/hdsiso_gate_writer.md
# hdsiso_gate_writer

Write-side driver for the latch-based serial-in/serial-out (SISO) storage chain built from transparent-high D-latch cells.
- Accepts bytes over a valid/ready handshake and serializes them MSB-first onto `sdata`.
- Generates two non-overlapping gate phases: `gate_b` drives even chain stages, `gate_a` drives odd chain stages.
- Sits between the user logic in the project wrapper and the hard latch array.

## Interface
- `PULSE_CYCLES`, default 2: clock cycles each gate phase is held high. Must be ≥1.
- `GAP_CYCLES`, default 1: non-overlap cycles, with both gates low, after each phase. Must be ≥1.
- `DEPTH`, default 16: number of latch pairs in the chain. Used only by the flush feature.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_data`  in  8  byte to shift into the chain.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a byte this cycle.
- `sdata`  out  1  serial data to the chain input, i.e. to the D pin of the first odd latch.
- `gate_a`  out  1  gate for the odd latch stages.
- `gate_b`  out  1  gate for the even latch stages.
- `busy`  out  1  shift sequence in progress.
- `flush`  in  1  start a zero-fill of the chain. Present only when `HDSISO_FLUSH_EN` is defined.

## Operation
- States: IDLE, SETUP, PH_B, GAP_B, PH_A, GAP_A.
- Reset values: state=IDLE; `sdata`=0, `gate_a`=0, `gate_b`=0, `busy`=0; `in_ready`=0 while `rst` is high.
- `in_ready` is 1 only in IDLE, and is derived from registered state only.
- Accept condition: `in_valid & in_ready` at a clock edge.
  - On accept, load `in_data` into the shift register, set bit index to 7, set `busy`=1, and go to SETUP.
- SETUP (1 cycle): `sdata` = current bit. Both gates are low.
- PH_B (`PULSE_CYCLES` cycles): `gate_b`=1. Even stages copy the preceding odd stages.
- GAP_B (`GAP_CYCLES` cycles): both gates low.
- PH_A (`PULSE_CYCLES` cycles): `gate_a`=1. The first odd stage captures `sdata`; the other odd stages capture the preceding even stages.
- GAP_A (`GAP_CYCLES` cycles): both gates low.
  - If bit index is 0: go to IDLE and set `busy`=0.
  - Otherwise: decrement bit index and go to SETUP.
- `sdata` is held stable from SETUP through the end of GAP_A. It changes only on entry to SETUP. It returns to 0 in IDLE.
- Invariant: `gate_a & gate_b` is never 1. Every gate edge is separated from the opposite gate's edge by at least `GAP_CYCLES` cycles.
- All outputs are registered, so the gates are glitch-free.
- `in_valid` while not ready is ignored: data is not captured and no error is raised.
- `rst` asserted mid-sequence: on the next edge both gates go to 0 and state goes to IDLE. The partially shifted byte is discarded. The chain contents are left undefined for the user to handle.

## Timing
- Bit period: 1 + 2·`PULSE_CYCLES` + 2·`GAP_CYCLES` cycles. With defaults this is 7 cycles.
- Byte period: 8 bit periods plus 1 IDLE cycle. With defaults this is 57 cycles from accept to the next possible accept.
- Example with defaults, accept at edge t:
  - SETUP at t+1.
  - `gate_b` high at t+2..t+3.
  - GAP_B at t+4.
  - `gate_a` high at t+5..t+6.
  - GAP_A at t+7.
  - The next bit's SETUP is at t+8.
  - The last GAP_A is at t+56.
  - IDLE, with `in_ready`=1, at t+57.
- Phase and gap lengths use a down-counter of width `$clog2(max(PULSE_CYCLES,GAP_CYCLES)+1)`.

## Configuration
- `HDSISO_FLUSH_EN` defined:
  - Adds the `flush` input.
  - In IDLE, `flush`=1 has priority over `in_valid`. It shifts `DEPTH` zero bits using the same per-bit sequence, with `busy`=1 and `in_ready`=0 throughout.
  - The bit counter widens to `$clog2(DEPTH)` bits.
- `HDSISO_FLUSH_EN` undefined:
  - No `flush` port.
  - `DEPTH` is ignored.
  - The bit counter is 3 bits.

## Structure
- Package `hdsiso_pkg`:
  - state enum `hdsiso_state_t`.
  - default constants `HDSISO_PULSE_DEF`=2 and `HDSISO_GAP_DEF`=1.
  - `HDSISO_BYTE_W`=8.
- Sub-module `hdsiso_phase_timer`: loadable down-counter with a `done` output. It is reused for both pulse and gap durations.

## Test plan
- Reset then idle → `in_ready`=1, `busy`=0, all gates and `sdata` 0 for 10 cycles.
- Accept 0xA5 with defaults → sampled at each `gate_a` fall, `sdata` = 1,0,1,0,0,1,0,1; `in_ready` returns at t+57; exactly 8 pulses on each gate.
- `in_valid` held high with 0x3C then 0xFF back-to-back → second accept exactly 57 cycles after the first; no gate overlap at any cycle (assertion).
- `PULSE_CYCLES`=3, `GAP_CYCLES`=2 → bit period 11; each gate is high for exactly 3 cycles, with at least 2 both-low cycles between phases.
- `rst` at t+20 during byte 0x81 → next edge: gates 0, `busy`=0, IDLE; a new accept of 0x00 then completes normally.
- `HDSISO_FLUSH_EN`, `DEPTH`=16, `flush` pulse in IDLE with `in_valid`=1 → flush wins; 16 bit periods with `sdata`=0 (112 cycles); `in_data` is not consumed.
